req_gen_pkt: RTL

- Packet-aware request generator for the AXI-Stream crossbar. Generalises the combinational single-slave request decoder.
- Produces the full M×S request matrix in one block, one request vector per slave.
- Locks each master's route from packet start until its TLAST beat is transferred.
- Detects out-of-range TDEST and routes that packet to a drop path with a saturating error counter.
- Sits between the slave-side stream inputs and the per-slave arbiters.

---
 rtl/xbar_pkg.sv | 17 +
 rtl/req_gen_lane.sv | 160 ++++++++++++++++
 rtl/req_gen_pkt.sv | 82 ++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared types and helpers for the AXI-Stream crossbar request path.
//   req_state_e  : per-master packet routing state
//   dest_width() : TDEST width needed to address m slaves (never below 1)
package xbar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LOCKED,
        DROP
    } req_state_e;

    function automatic int dest_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/req_gen_lane.sv
// One master's packet-aware request generator.
// Tracks a packet from its first beat to its TLAST transfer, holds the routed
// destination while the packet is in flight, and diverts packets with an
// out-of-range TDEST to the drop path while counting them.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   valid     : TVALID from the master
//   ready     : TREADY seen by the master (crossbar or drop sink)
//   last      : TLAST from the master
//   dest      : TDEST from the master
//   grant     : grant from each slave arbiter for this master (one bit per slave)
//   req       : request column, at most one bit set
//   lock      : route is granted and held until TLAST
//   drop      : packet is being sunk by the drop path
//   err       : one-cycle pulse after a bad-TDEST packet starts
//   cnt       : saturating count of dropped packets
//   state     : FSM state, exported for observation
//
// Handshake: a beat transfers on a cycle where valid and ready are both high;
// once valid rises it must stay high until that transfer happens.
module req_gen_lane
    import xbar_pkg::*;
#(
    parameter int M_DATA_COUNT = 3,
    parameter int CNT_WIDTH    = 8,
    parameter int T_DEST_WIDTH = dest_width(M_DATA_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic                    ready,
    input  logic                    last,
    input  logic [T_DEST_WIDTH-1:0] dest,
    input  logic [M_DATA_COUNT-1:0] grant,
    output logic [M_DATA_COUNT-1:0] req,
    output logic                    lock,
    output logic                    drop,
    output logic                    err,
    output logic [CNT_WIDTH-1:0]    cnt,
    output req_state_e              state
);

    logic [T_DEST_WIDTH-1:0] dest_q;
    logic [M_DATA_COUNT-1:0] new_col;   // one-hot of the incoming TDEST
    logic [M_DATA_COUNT-1:0] held_col;  // one-hot of the latched TDEST
    logic                    dest_ok;
    logic                    new_grant;
    logic                    held_grant;
    logic                    hs;
    logic                    eop;

    // A TDEST beyond the slave count decodes to an all-zero column, which
    // doubles as the out-of-range detector.
    always_comb begin
        new_col  = '0;
        held_col = '0;
        for (int j = 0; j < M_DATA_COUNT; j++) begin
            new_col[j]  = (dest == T_DEST_WIDTH'(j));
            held_col[j] = (dest_q == T_DEST_WIDTH'(j));
        end
        dest_ok    = |new_col;
        new_grant  = |(grant & new_col);
        held_grant = |(grant & held_col);
        hs         = valid & ready;
        eop        = hs & last;
    end

    // Idle requests follow the live TDEST with zero latency; once a packet is
    // routed only the latched destination is requested.
    always_comb begin
        req = '0;
        case (state)
            IDLE:        req = valid ? new_col : '0;
            REQ, LOCKED: req = held_col;
            default:     req = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dest_q <= '0;
            lock   <= 1'b0;
            drop   <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        if (!dest_ok) begin
                            err <= 1'b1;
                            if (cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
                            // A single-beat bad packet is already sunk.
                            if (!eop) begin
                                state <= DROP;
                                drop  <= 1'b1;
                            end
                        end else begin
                            dest_q <= dest;
                            if (new_grant) begin
                                if (!eop) begin
                                    state <= LOCKED;
                                    lock  <= 1'b1;
                                end
                            end else begin
                                state <= REQ;
                            end
                        end
                    end
                end
                REQ: begin
                    if (held_grant) begin
                        if (eop) begin
                            state <= IDLE;
                        end else begin
                            state <= LOCKED;
                            lock  <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (eop) begin
                        state <= IDLE;
                        lock  <= 1'b0;
                    end
                end
                DROP: begin
                    if (eop) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    lock  <= 1'b0;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

    // A pending beat may not be withdrawn while waiting for a grant.
    a_req_valid_held: assert property (@(posedge clk) disable iff (rst)
        (state == REQ) |-> valid);

    // The arbiter must hold the grant for the whole packet.
    a_locked_grant: assert property (@(posedge clk) disable iff (rst)
        (state == LOCKED) |-> held_grant);

    // Grants only ever answer an active request.
    a_grant_requested: assert property (@(posedge clk) disable iff (rst)
        (grant & ~req) == '0);

    a_req_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req));

endmodule

// File: rtl/req_gen_pkt.sv
// Packet-aware request generator for the AXI-Stream crossbar.
// Builds the full slave-by-master request matrix from one lane per master and
// feeds it to the per-slave arbiters.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   s_valid_i   : TVALID per master
//   s_ready_i   : TREADY seen by each master (drop path included)
//   s_last_i    : TLAST per master
//   s_dest_i    : TDEST per master
//   grant_i     : grant_i[j][i], slave j's arbiter grants master i
//   req_o       : req_o[j][i], master i requests slave j
//   lock_o      : master holds a granted route
//   drop_o      : master is in drop mode; the crossbar sinks its beats
//   err_o       : one-cycle pulse when a bad-TDEST packet starts
//   drop_cnt_o  : saturating dropped-packet count per master
module req_gen_pkt
    import xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    parameter  int CNT_WIDTH    = 8,
    localparam int T_DEST_WIDTH = dest_width(M_DATA_COUNT)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
    input  logic [S_DATA_COUNT-1:0]                   s_ready_i,
    input  logic [S_DATA_COUNT-1:0]                   s_last_i,
    input  logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i,
    input  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] grant_i,
    output logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req_o,
    output logic [S_DATA_COUNT-1:0]                   lock_o,
    output logic [S_DATA_COUNT-1:0]                   drop_o,
    output logic [S_DATA_COUNT-1:0]                   err_o,
    output logic [S_DATA_COUNT-1:0][CNT_WIDTH-1:0]    drop_cnt_o
);

    // Lanes work on per-master columns; the arbiters see per-slave rows.
    logic [S_DATA_COUNT-1:0][M_DATA_COUNT-1:0] grant_col;
    logic [S_DATA_COUNT-1:0][M_DATA_COUNT-1:0] req_col;
    req_state_e                                lane_state [S_DATA_COUNT];

    always_comb begin
        req_o     = '0;
        grant_col = '0;
        for (int i = 0; i < S_DATA_COUNT; i++) begin
            for (int j = 0; j < M_DATA_COUNT; j++) begin
                req_o[j][i]     = req_col[i][j];
                grant_col[i][j] = grant_i[j][i];
            end
        end
    end

    for (genvar i = 0; i < S_DATA_COUNT; i++) begin : g_lane
        req_gen_lane #(
            .M_DATA_COUNT (M_DATA_COUNT),
            .CNT_WIDTH    (CNT_WIDTH),
            .T_DEST_WIDTH (T_DEST_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .valid (s_valid_i[i]),
            .ready (s_ready_i[i]),
            .last  (s_last_i[i]),
            .dest  (s_dest_i[i]),
            .grant (grant_col[i]),
            .req   (req_col[i]),
            .lock  (lock_o[i]),
            .drop  (drop_o[i]),
            .err   (err_o[i]),
            .cnt   (drop_cnt_o[i]),
            .state (lane_state[i])
        );

        // The registered lock/drop flags must always agree with the state.
        a_flags_match_state: assert property (@(posedge clk) disable iff (rst)
            (lock_o[i] == (lane_state[i] == LOCKED)) &&
            (drop_o[i] == (lane_state[i] == DROP)));
    end

endmodule
